// File: rtl/fp_mult_collector.sv
// fp_mult_collector: small FIFO that collects single-precision multiplier
// results with their status bytes. Alongside the queue it keeps sticky
// exception flags and saturating result and exception counters.
module fp_mult_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_z,
    input  logic [7:0]               in_status,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_z,
    output logic [7:0]               out_status,
    input  logic                     clr_flags,
    output logic [5:0]               sticky_flags,
    output logic [CNT_W-1:0]         result_cnt,
    output logic [CNT_W-1:0]         excp_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      mem_z [DEPTH];
    logic [7:0]       mem_s [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [5:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic             push, pop, excp_ev;

    // Handshakes and head-of-queue presentation (zeroed while empty)
    always_comb begin
        in_ready   = (level_q != LW'(DEPTH));
        out_valid  = (level_q != '0);
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        excp_ev    = in_status[6] | in_status[5] | in_status[3];
        out_z      = out_valid ? mem_z[rd_ptr_q] : 32'd0;
        out_status = out_valid ? mem_s[rd_ptr_q] : 8'd0;
    end

    // Pointer and occupancy next-state; DEPTH is a power of two so the
    // pointers wrap naturally at DEPTH-1 -> 0
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Flag/counter next-state: a clear is applied first so a push in the
    // same cycle is still recorded on top of the cleared values
    always_comb begin
        sticky_d = sticky_q;
        rcnt_d   = rcnt_q;
        ecnt_d   = ecnt_q;
        if (clr_flags) begin
            sticky_d = '0;
            rcnt_d   = '0;
            ecnt_d   = '0;
        end
        if (push) begin
            sticky_d = sticky_d | in_status[7:2];
            if (rcnt_d != CNT_MAX) rcnt_d = rcnt_d + CNT_W'(1);
            if (excp_ev && (ecnt_d != CNT_MAX)) ecnt_d = ecnt_d + CNT_W'(1);
        end
    end

    // Queue storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_z[wr_ptr_q] <= in_z;
            mem_s[wr_ptr_q] <= in_status;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= '0;
            rcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            rcnt_q   <= rcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign sticky_flags = sticky_q;
    assign result_cnt   = rcnt_q;
    assign excp_cnt     = ecnt_q;
    assign level        = level_q;

endmodule

// File: tb/tb_fp_mult_collector.sv
// Bench for fp_mult_collector: scoreboard queue of expected entries plus a
// reference model of flags/counters; a CNT_W=4 instance shares the stimulus
// to exercise counter saturation.
module tb_fp_mult_collector;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_z = '0;
    logic [7:0]  in_status = '0;
    logic        out_ready = 1'b0;
    logic        clr_flags = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic [5:0]  sticky_flags;
    logic [15:0] result_cnt, excp_cnt;
    logic [2:0]  level;

    logic        in_ready4, out_valid4;
    logic [31:0] out_z4;
    logic [7:0]  out_status4;
    logic [5:0]  sticky_flags4;
    logic [3:0]  result_cnt4, excp_cnt4;
    logic [2:0]  level4;

    int checks = 0;
    int failures = 0;

    logic [39:0] q[$];
    logic [5:0]  m_sticky = '0;
    int          m_rc = 0;
    int          m_ec = 0;

    always #5 clk = ~clk;

    fp_mult_collector #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_status(in_status), .out_valid(out_valid),
        .out_ready(out_ready), .out_z(out_z), .out_status(out_status),
        .clr_flags(clr_flags), .sticky_flags(sticky_flags),
        .result_cnt(result_cnt), .excp_cnt(excp_cnt), .level(level)
    );

    fp_mult_collector #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_z(in_z), .in_status(in_status), .out_valid(out_valid4),
        .out_ready(out_ready), .out_z(out_z4), .out_status(out_status4),
        .clr_flags(clr_flags), .sticky_flags(sticky_flags4),
        .result_cnt(result_cnt4), .excp_cnt(excp_cnt4), .level(level4)
    );

    // One clock of scoreboard bookkeeping: decide handshakes from the model's
    // occupancy at the negedge, compare popped data, then advance to posedge+1
    task automatic tick();
        bit acc, pp;
        logic [39:0] e;
        @(negedge clk);
        acc = in_valid && (q.size() != DEPTH);
        pp  = out_ready && (q.size() != 0);
        checks++;
        if (out_valid !== (q.size() != 0)) begin
            failures++;
            $display("FAIL out_valid got=%b exp=%b", out_valid, q.size() != 0);
        end
        if (pp) begin
            e = q.pop_front();
            checks++;
            if ({out_z, out_status} !== e) begin
                failures++;
                $display("FAIL pop_data got=%h_%h exp=%h_%h", out_z, out_status, e[39:8], e[7:0]);
            end
        end
        if (clr_flags) begin
            m_sticky = '0; m_rc = 0; m_ec = 0;
        end
        if (acc) begin
            q.push_back({in_z, in_status});
            m_sticky = m_sticky | in_status[7:2];
            if (m_rc < 65535) m_rc++;
            if ((in_status[6] | in_status[5] | in_status[3]) && m_ec < 65535) m_ec++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_z !== 32'd0 || out_status !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b z=%h s=%h exp 1 0 0 0", in_ready, out_valid, out_z, out_status);
        end
        checks++;
        if (level !== 3'd0 || result_cnt !== 16'd0 || excp_cnt !== 16'd0 || sticky_flags !== 6'd0) begin
            failures++;
            $display("FAIL reset_state got lvl=%0d rc=%0d ec=%0d fl=%b exp all 0", level, result_cnt, excp_cnt, sticky_flags);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_z = 32'h40C00000; in_status = 8'h00; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_z = 32'hDEADBEEF; in_status = 8'hFF;
        checks++;
        if (out_valid !== 1'b1 || out_z !== 32'h40C00000 || level !== 3'd1) begin
            failures++;
            $display("FAIL single_out got vld=%b z=%h lvl=%0d exp 1 40c00000 1", out_valid, out_z, level);
        end
        checks++;
        if (result_cnt !== 16'd1 || excp_cnt !== 16'd0) begin
            failures++;
            $display("FAIL single_cnt got rc=%0d ec=%0d exp 1 0", result_cnt, excp_cnt);
        end
        tick();
        checks++;
        if (level !== 3'd1) begin
            failures++;
            $display("FAIL ignored_input got lvl=%0d exp 1", level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_z = 32'h3F800000 + i; in_status = 8'(i + 1);
            tick();
            if (i == 3) begin
                checks++;
                if (in_ready !== 1'b0 || level !== 3'd4) begin
                    failures++;
                    $display("FAIL full_after4 got rdy=%b lvl=%0d exp 0 4", in_ready, level);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd4 || q.size() != 4) begin
            failures++;
            $display("FAIL fifth_rejected got lvl=%0d exp 4", level);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || out_z !== 32'd0) begin
            failures++;
            $display("FAIL drained got lvl=%0d vld=%b z=%h exp 0 0 0", level, out_valid, out_z);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_z = 32'hC0000000 + i; in_status = 8'h03;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            in_z = 32'hC0000000 + i; in_status = 8'(i);
            tick();
            checks++;
            if (level !== 3'd2) begin
                failures++;
                $display("FAIL wrap_level iter=%0d got=%0d exp=2", i, level);
            end
        end
        in_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b0;
        checks++;
        if (q.size() != 0 || level !== 3'd0) begin
            failures++;
            $display("FAIL wrap_drain got lvl=%0d exp 0", level);
        end
    endtask

    task automatic test_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checks++;
        if (sticky_flags !== 6'd0 || result_cnt !== 16'd0 || excp_cnt !== 16'd0) begin
            failures++;
            $display("FAIL clr_no_push got fl=%b rc=%0d ec=%0d exp 0 0 0", sticky_flags, result_cnt, excp_cnt);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_z = 32'h7FC00000; in_status = 8'h20;
        tick();
        in_z = 32'h3EAAAAAB; in_status = 8'h04;
        tick();
        in_valid = 1'b0;
        checks++;
        if (sticky_flags !== 6'b001001 || excp_cnt !== 16'd1 || result_cnt !== 16'(m_rc)) begin
            failures++;
            $display("FAIL flags_accum got fl=%b ec=%0d rc=%0d exp 001001 1 %0d", sticky_flags, excp_cnt, result_cnt, m_rc);
        end
        in_valid = 1'b1; clr_flags = 1'b1; in_z = 32'h7F800000; in_status = 8'h40;
        tick();
        in_valid = 1'b0; clr_flags = 1'b0;
        checks++;
        if (sticky_flags !== 6'b010000 || result_cnt !== 16'd1 || excp_cnt !== 16'd1) begin
            failures++;
            $display("FAIL clr_with_push got fl=%b rc=%0d ec=%0d exp 010000 1 1", sticky_flags, result_cnt, excp_cnt);
        end
        checks++;
        if (sticky_flags !== m_sticky || excp_cnt !== 16'(m_ec)) begin
            failures++;
            $display("FAIL flags_model got fl=%b ec=%0d exp %b %0d", sticky_flags, excp_cnt, m_sticky, m_ec);
        end
        tick(); tick();
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_status = 8'h08;
        for (int i = 0; i < 20; i++) begin
            in_z = 32'h7F7FFF00 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++;
        if (result_cnt4 !== 4'd15 || excp_cnt4 !== 4'd15) begin
            failures++;
            $display("FAIL sat_cnt4 got rc=%0d ec=%0d exp 15 15", result_cnt4, excp_cnt4);
        end
        checks++;
        if (result_cnt !== 16'd20 || excp_cnt !== 16'd20 || sticky_flags !== 6'b000010) begin
            failures++;
            $display("FAIL sat_cnt16 got rc=%0d ec=%0d fl=%b exp 20 20 000010", result_cnt, excp_cnt, sticky_flags);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_z = 32'h41200000 + i; in_status = 8'h24;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset_level got=%0d exp=3", level);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_z !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got lvl=%0d vld=%b rdy=%b z=%h exp 0 0 1 0", level, out_valid, in_ready, out_z);
        end
        checks++;
        if (result_cnt !== 16'd0 || excp_cnt !== 16'd0 || sticky_flags !== 6'd0) begin
            failures++;
            $display("FAIL async_reset_cnt got rc=%0d ec=%0d fl=%b exp 0 0 0", result_cnt, excp_cnt, sticky_flags);
        end
        q.delete(); m_sticky = '0; m_rc = 0; m_ec = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b1; in_z = 32'hBF800000; in_status = 8'h80;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_z !== 32'hBF800000 || out_status !== 8'h80 || level !== 3'd1) begin
            failures++;
            $display("FAIL first_push_after_reset got vld=%b z=%h s=%h lvl=%0d exp 1 bf800000 80 1", out_valid, out_z, out_status, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_flags();
        test_saturation();
        test_async_reset();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_mult_collector.md
FP_MULT_COLLECTOR -- requirements
Module: fp_mult_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result queue entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the result and exception counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  the multiplier result is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  the block can accept a result this cycle.
REQ-007 SHALL have port in_z  input  32  the IEEE-754 single-precision product z.
REQ-008 SHALL have port in_status  input  8  the multiplier status: [7] zero, [6] inf, [5] nan, [4] tiny, [3] huge, [2] inexact, [1:0] reserved.
REQ-009 SHALL have port out_valid  output  1  the head entry is presented.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the head entry.
REQ-011 SHALL have port out_z  output  32  the head entry product.
REQ-012 SHALL have port out_status  output  8  the head entry status.
REQ-013 SHALL have port clr_flags  input  1  synchronous clear of the sticky flags and counters.
REQ-014 SHALL have port sticky_flags  output  6  cumulative OR of in_status[7:2] over accepted results.
REQ-015 SHALL have port result_cnt  output  CNT_W  number of accepted results, saturating.
REQ-016 SHALL have port excp_cnt  output  CNT_W  number of accepted results with nan|inf|huge set, saturating.
REQ-017 SHALL have port level  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 Push SHALL occur on a cycle with in_valid && in_ready; pop SHALL occur on a cycle with out_valid && out_ready.
REQ-019 in_ready SHALL equal (level != DEPTH); no push when full, even with a simultaneous pop.
REQ-020 out_valid SHALL equal (level != 0); there is no fall-through, so accept-to-out_valid latency is exactly 1 cycle.
REQ-021 out_z/out_status SHALL present the entry at the read pointer and SHALL be 0 when level == 0.
REQ-022 Write and read pointers SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-023 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and advance both pointers.
REQ-024 Order SHALL be strictly FIFO; in_status[1:0] SHALL be stored as received.
REQ-025 On push, sticky_flags SHALL become sticky_flags | in_status[7:2].
REQ-026 On push, result_cnt SHALL increment by 1 and hold at 2^CNT_W-1.
REQ-027 On push with any of in_status[6], [5], [3] set, excp_cnt SHALL increment by 1 and hold at 2^CNT_W-1.
REQ-028 If clr_flags is high with no push, sticky_flags, result_cnt and excp_cnt SHALL become 0 next cycle.
REQ-029 If clr_flags is high with a push, the flags SHALL become in_status[7:2], result_cnt SHALL become 1, and excp_cnt SHALL become 1 or 0 per REQ-027, so the new event is not lost.
REQ-030 clr_flags SHALL NOT affect queue contents, pointers or level.
REQ-031 in_z/in_status SHALL be ignored when no push occurs.

Reset
REQ-032 rst high SHALL immediately set pointers, level, sticky_flags, result_cnt and excp_cnt to 0.
REQ-033 During reset, outputs SHALL be: in_ready=1, out_valid=0, out_z=0, out_status=0.
REQ-034 Reset mid-operation SHALL discard all queued entries; queue memory contents need no reset.
REQ-035 The first push SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-036 Single result: push z=0x40C00000, status=0x00 with out_ready=0 -> next cycle out_valid=1, out_z=0x40C00000, level=1, result_cnt=1, excp_cnt=0.
REQ-037 Fill/full: push 5 results back-to-back with out_ready=0 (DEPTH=4) -> in_ready=0 after the 4th; the 5th is not accepted; level=4; pops return entries 1-4 in order.
REQ-038 Wrap: run 10 pushes interleaved with pops (push+pop same cycle at level=2) -> level stays 2 and the output sequence matches the input order across pointer wrap.
REQ-039 Flags: push status 0x20 (nan), then 0x04 (inexact) -> sticky_flags=6'b001001 and excp_cnt=1; clr_flags together with a push of 0x40 -> sticky_flags=6'b010000, result_cnt=1, excp_cnt=1.
REQ-040 Saturation (CNT_W=4): push 20 results with status 0x08 -> result_cnt=15 and excp_cnt=15.
REQ-041 Async reset: assert rst between clock edges with level=3 -> level=0, out_valid=0, in_ready=1 and counters=0 without waiting for a clock edge.
